// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/memory-side types for the multicore RAM path.
//   word_t      - 32-bit machine word
//   ramstate_t  - RAM port status reported back to the arbiter
//   arb_state_t - RAM bus arbiter FSM state
//   req_kind_t  - class of the granted requester (icache or dcache)
// Helpers compute pointer widths and test for power-of-two core counts.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_SERVE = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_kind_t;

  // Pointer width for n requesters; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when n is a power of two, so a pointer can wrap by truncation.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: bundle of the per-core cache request signals and the
// single RAM port handled by ram_bus_arbiter.
//   Cache side : iREN/iaddr, dREN/dWEN/daddr/dstore (requests),
//                iwait/dwait/iload/dload (responses); core n at [32n+31:32n].
//   RAM side   : ramaddr/ramstore/ramREN/ramWEN (commands), ramload/ramstate.
// modport slave  - arbiter view (receives cache requests, drives the RAM).
// modport master - environment view (caches and RAM model).
interface ram_bus_arbiter_if #(parameter int CPUS = 2);
  import cpu_types_pkg::*;

  logic [CPUS-1:0]        iREN;
  logic [CPUS*WORD_W-1:0] iaddr;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*WORD_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  word_t                  ramaddr;
  word_t                  ramstore;
  logic                   ramREN;
  logic                   ramWEN;
  word_t                  ramload;
  ramstate_t              ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );

endinterface

// File: rtl/ram_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req[N] - request vector
//   ptr    - index to start searching from
//   any    - 1 when at least one request is set
//   idx    - first requesting index at or after ptr, wrapping modulo N
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  int          cand_s;
  logic [N-1:0] rot_s;
  logic         hit_s;

  // Walk N candidates starting at ptr; the first hit wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    cand_s = 0;
    rot_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s = int'(ptr) + k;
      cand_s = (cand_s >= N) ? (cand_s - N) : cand_s;
      rot_s  = req >> cand_s;
      hit_s  = rot_s[0] & ~any;
      idx    = hit_s ? PW'(cand_s) : idx;
      any    = any | hit_s;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one RAM port between the icache and dcache of CPUS
// cores. dcache requests beat icache requests; within a class the grant
// rotates round-robin. A grant is held until the RAM reports ACCESS.
//   CLK  - system clock
//   nRST - asynchronous active-low reset
//   bus  - cache request/response and RAM port signals (slave view)
module ram_bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  ram_bus_arbiter_if.slave    bus
);

  localparam int PW   = ptr_width(CPUS);
  localparam bit POW2 = is_pow2(CPUS);

  arb_state_t    state_r;
  req_kind_t     grant_kind_r;
  logic [PW-1:0] grant_cpu_r;
  logic [PW-1:0] rr_d_r;
  logic [PW-1:0] rr_i_r;

  logic [CPUS-1:0] d_req_s;
  logic            d_any_s;
  logic            i_any_s;
  logic [PW-1:0]   d_idx_s;
  logic [PW-1:0]   i_idx_s;
  logic            i_ren_g_s;
  logic            d_ren_g_s;
  logic            d_wen_g_s;
  logic            req_live_s;
  logic            ack_s;

  word_t iaddr_a_s  [CPUS];
  word_t daddr_a_s  [CPUS];
  word_t dstore_a_s [CPUS];

  // Advance a pointer past the served core; non-power-of-two counts need an explicit wrap.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    if (POW2 && (CPUS > 1)) begin
      return p + PW'(1);
    end else begin
      return (p == PW'(CPUS - 1)) ? '0 : (p + PW'(1));
    end
  endfunction

  assign d_req_s = bus.dREN | bus.dWEN;

  rr_picker #(.N(CPUS), .PW(PW)) u_pick_d (
    .req (d_req_s),
    .ptr (rr_d_r),
    .any (d_any_s),
    .idx (d_idx_s)
  );

  rr_picker #(.N(CPUS), .PW(PW)) u_pick_i (
    .req (bus.iREN),
    .ptr (rr_i_r),
    .any (i_any_s),
    .idx (i_idx_s)
  );

  // Per-core unpacking of the flat buses and per-core response generation.
  for (genvar n = 0; n < CPUS; n++) begin : g_core
    logic sel_s;
    assign sel_s           = (grant_cpu_r == PW'(n));
    assign iaddr_a_s[n]    = bus.iaddr[n*WORD_W +: WORD_W];
    assign daddr_a_s[n]    = bus.daddr[n*WORD_W +: WORD_W];
    assign dstore_a_s[n]   = bus.dstore[n*WORD_W +: WORD_W];
    assign bus.iwait[n]    = ~(ack_s & (grant_kind_r == REQ_I) & sel_s);
    assign bus.dwait[n]    = ~(ack_s & (grant_kind_r == REQ_D) & sel_s);
    assign bus.iload[n*WORD_W +: WORD_W] =
      (ack_s && (grant_kind_r == REQ_I) && sel_s) ? bus.ramload : '0;
    assign bus.dload[n*WORD_W +: WORD_W] =
      (ack_s && (grant_kind_r == REQ_D) && sel_s) ? bus.ramload : '0;
  end

  // Live request bits of the granted requester; a dropped request aborts the grant.
  always_comb begin
    i_ren_g_s  = bus.iREN[grant_cpu_r];
    d_ren_g_s  = bus.dREN[grant_cpu_r];
    d_wen_g_s  = bus.dWEN[grant_cpu_r];
    req_live_s = (grant_kind_r == REQ_D) ? (d_ren_g_s | d_wen_g_s) : i_ren_g_s;
    ack_s      = (state_r == ARB_SERVE) && req_live_s && (bus.ramstate == ACCESS);
  end

  // RAM command follows the granted requester's inputs; a write wins over a read.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (state_r == ARB_SERVE) begin
      if (grant_kind_r == REQ_I) begin
        bus.ramREN  = i_ren_g_s;
        bus.ramaddr = iaddr_a_s[grant_cpu_r];
      end else if (d_wen_g_s) begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = daddr_a_s[grant_cpu_r];
        bus.ramstore = dstore_a_s[grant_cpu_r];
      end else begin
        bus.ramREN  = d_ren_g_s;
        bus.ramaddr = daddr_a_s[grant_cpu_r];
      end
    end else begin
      bus.ramREN = 1'b0;
    end
  end

  // Grant FSM: pick in IDLE, hold in SERVE until ACCESS or the request drops.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= ARB_IDLE;
      grant_kind_r <= REQ_I;
      grant_cpu_r  <= '0;
      rr_d_r       <= '0;
      rr_i_r       <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (d_any_s) begin
            grant_cpu_r  <= d_idx_s;
            grant_kind_r <= REQ_D;
            state_r      <= ARB_SERVE;
          end else if (i_any_s) begin
            grant_cpu_r  <= i_idx_s;
            grant_kind_r <= REQ_I;
            state_r      <= ARB_SERVE;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_SERVE: begin
          if (!req_live_s) begin
            state_r <= ARB_IDLE;
          end else if (bus.ramstate == ACCESS) begin
            state_r <= ARB_IDLE;
            if (grant_kind_r == REQ_D) begin
              rr_d_r <= inc_ptr(grant_cpu_r);
            end else begin
              rr_i_r <= inc_ptr(grant_cpu_r);
            end
          end else begin
            // FREE/BUSY/ERROR: keep the grant and retry.
            state_r <= ARB_SERVE;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
